// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_cycle #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  ALUSrcE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic [2:0]            ALUControlE,
  input  logic [DATA_WIDTH-1:0] RD1_E,
  input  logic [DATA_WIDTH-1:0] RD2_E,
  input  logic [DATA_WIDTH-1:0] Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_WIDTH-1:0] ALU_ResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCPlus4M
);

  logic                  reg_write_q, reg_write_d;
  logic                  mem_write_q, mem_write_d;
  logic                  result_src_q, result_src_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  lt;
  logic                  zero;

  // Select 10 reads the EX/MEM register, i.e. the previous instruction
  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardB_E)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = alu_q;
      default: write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data;
  assign lt    = $signed(src_a) < $signed(src_b);

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_d = src_a + src_b;
      3'b001:  alu_d = src_a - src_b;
      3'b010:  alu_d = src_a & src_b;
      3'b011:  alu_d = src_a | src_b;
      3'b101:  alu_d = {{(DATA_WIDTH-1){1'b0}}, lt};
      default: alu_d = '0;
    endcase
  end

  assign zero      = (alu_d == '0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  assign reg_write_d  = RegWriteE;
  assign mem_write_d  = MemWriteE;
  assign result_src_d = ResultSrcE;
  assign rd_d         = RD_E;
  assign wdata_d      = write_data;
  assign pc4_d        = PCPlus4E;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      pc4_q        <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      pc4_q        <= pc4_d;
    end
  end

  assign RegWriteM   = reg_write_q;
  assign MemWriteM   = mem_write_q;
  assign ResultSrcM  = result_src_q;
  assign RD_M        = rd_q;
  assign ALU_ResultM = alu_q;
  assign WriteDataM  = wdata_q;
  assign PCPlus4M    = pc4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: directed plan cases then random
// traffic against an arithmetic reference model.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;

  execute_cycle #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_alu_prev = 32'h0;
  string       cur_tag;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] rf);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return m_alu_prev;
    return rf;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      3'd0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000)
                       % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb2) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Called just after the inputs are applied on the falling edge
  task automatic issue();
    exp_t        e;
    logic [31:0] a, wd, b, r;
    #1;
    a  = fwd(ForwardA_E, RD1_E);
    wd = fwd(ForwardB_E, RD2_E);
    b  = ALUSrcE ? Imm_Ext_E : wd;
    r  = alu_model(ALUControlE, a, b);
    check({cur_tag, ".PCTargetE"}, PCTargetE, PCE + Imm_Ext_E);
    check({cur_tag, ".PCSrcE"}, {31'd0, PCSrcE},
          {31'd0, BranchE && (r == 32'd0)});
    if (rst) begin
      e = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, cur_tag};
    end else begin
      e = '{RegWriteE, MemWriteE, ResultSrcE, RD_E, r, wd, PCPlus4E,
            cur_tag};
    end
    m_alu_prev = e.alu;
    sb.push_back(e);
  endtask

  task automatic drive(input string tag, input logic r,
                       input logic rw, input logic asrc, input logic mw,
                       input logic rs, input logic br, input logic [2:0] op,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] rw_v,
                       input logic [1:0] fa, input logic [1:0] fb);
    @(negedge clk);
    cur_tag = tag;
    rst = r; RegWriteE = rw; ALUSrcE = asrc; MemWriteE = mw;
    ResultSrcE = rs; BranchE = br; ALUControlE = op;
    RD1_E = d1; RD2_E = d2; Imm_Ext_E = imm; RD_E = rd;
    PCE = pc; PCPlus4E = pc + 32'd4; ResultW = rw_v;
    ForwardA_E = fa; ForwardB_E = fb;
    issue();
  endtask

  // Monitor: the EX/MEM register presents a new result after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, e.rw});
        check({e.tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, e.mw});
        check({e.tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, {31'd0, e.rs});
        check({e.tag, ".RD_M"}, {27'd0, RD_M}, {27'd0, e.rd});
        check({e.tag, ".ALU_ResultM"}, ALU_ResultM, e.alu);
        check({e.tag, ".WriteDataM"}, WriteDataM, e.wd);
        check({e.tag, ".PCPlus4M"}, PCPlus4M, e.pc4);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
    BranchE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    RD_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    ForwardA_E = 0; ForwardB_E = 0;
    cur_tag = "init";

    drive("reset", 1, 1, 0, 1, 1, 0, 3'd0, 32'h11, 32'h22, 32'h40, 5'd7,
          32'h1000, 32'h33, 2'd0, 2'd0);
    drive("add", 0, 1, 0, 0, 0, 0, 3'd0, 32'd5, 32'd7, 32'd0, 5'd3,
          32'h4, 32'd0, 2'd0, 2'd0);
    drive("fwd_exex", 0, 1, 0, 0, 0, 0, 3'd1, 32'd0, 32'd2, 32'd0, 5'd4,
          32'h8, 32'd0, 2'd2, 2'd0);
    drive("fwd_memwb", 0, 0, 1, 1, 0, 0, 3'd0, 32'h100, 32'd0, 32'd4,
          5'd0, 32'hC, 32'hA5A5A5A5, 2'd0, 2'd1);
    drive("beq_taken", 0, 0, 0, 0, 0, 1, 3'd1, 32'd9, 32'd9, 32'd16,
          5'd0, 32'h20, 32'd0, 2'd0, 2'd0);
    drive("beq_not", 0, 0, 0, 0, 0, 1, 3'd1, 32'd9, 32'd8, 32'd16,
          5'd0, 32'h20, 32'd0, 2'd0, 2'd0);
    drive("add_wrap", 0, 1, 0, 0, 0, 0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0,
          5'd5, 32'h24, 32'd0, 2'd0, 2'd0);
    drive("slt_neg", 0, 1, 0, 0, 0, 0, 3'd5, 32'hFFFFFFFF, 32'd1, 32'd0,
          5'd6, 32'h28, 32'd0, 2'd0, 2'd0);
    drive("rst_mid", 1, 1, 0, 0, 0, 0, 3'd0, 32'd3, 32'd4, 32'd0,
          5'd6, 32'h2C, 32'd0, 2'd0, 2'd0);
    drive("fwd_after_rst", 0, 1, 0, 0, 0, 0, 3'd0, 32'd77, 32'd0, 32'd0,
          5'd1, 32'h30, 32'd0, 2'd2, 2'd2);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] d1, d2;
      d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
      d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
      drive("rand", $urandom_range(0, 19) == 0, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), d1, d2, $urandom, 5'($urandom), $urandom,
            $urandom, 2'($urandom), 2'($urandom));
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    check("drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
